// File: rtl/i2c_write_master_if.sv
// i2c_write_master_if
//   Bundles the sequencer handshake and the open-drain pad signals of the
//   I2C write engine.
//   slave  : engine view (receives start/payload/sda_i, drives status and pads)
//   master : surrounding logic view (config sequencer plus pad wrapper)
//   Signals:
//     start      request one write transaction
//     address    7-bit slave address (sent as {address,0})
//     data_0     first payload byte (register sub-address)
//     data_1     second payload byte (register value)
//     busy       transaction in progress, includes a start request seen in IDLE
//     done       one-cycle pulse when a transaction ends
//     ack_error  sticky NACK flag of the last transaction
//     scl_o      0 = pull SCL low, 1 = release
//     sda_o      0 = pull SDA low, 1 = release
//     sda_i      sampled SDA pad value
interface i2c_write_master_if;
  logic       start;
  logic [6:0] address;
  logic [7:0] data_0;
  logic [7:0] data_1;
  logic       busy;
  logic       done;
  logic       ack_error;
  logic       scl_o;
  logic       sda_o;
  logic       sda_i;

  modport slave (
    input  start, address, data_0, data_1, sda_i,
    output busy, done, ack_error, scl_o, sda_o
  );

  modport master (
    output start, address, data_0, data_1, sda_i,
    input  busy, done, ack_error, scl_o, sda_o
  );
endinterface

// File: rtl/i2c_write_master.sv
// i2c_write_master
//   Single-master, write-only I2C engine. Each accepted start emits
//   START, {address,0}, data_0, data_1, STOP on open-drain SCL/SDA with an
//   ACK check after every byte. A NACK skips the remaining bytes and goes
//   straight to STOP. No clock stretching, no arbitration.
//   Ports:
//     i_clk   system clock
//     i_rst   synchronous, active-high reset
//     bus     i2c_write_master_if.slave (handshake, status, pads)
//   Parameter:
//     CLK_DIV clk cycles per SCL quarter period (>= 2)
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | bus released, waiting for start
//   START | 4q: SDA falls while SCL high in q2
//   BIT   | 4q per data bit, SDA set in q0, SCL high in q2-q3
//   ACK   | 4q, SDA released, slave answer sampled at end of q2
//   STOP  | 4q: SCL rises in q1, SDA rises in q2
module i2c_write_master #(
  parameter int CLK_DIV = 125
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  i2c_write_master_if.slave     bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t           r_state;
  logic [1:0]       r_q;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [1:0]       r_byte;
  logic             r_scl;
  logic             r_sda;
  logic             r_done;
  logic             r_ack_error;
  logic [6:0]       r_addr;
  logic [7:0]       r_d0;
  logic [7:0]       r_d1;

  state_t           w_nxt_state;
  logic [1:0]       w_nxt_q;
  logic [DIV_W-1:0] w_nxt_div;
  logic [2:0]       w_nxt_bit;
  logic [1:0]       w_nxt_byte;
  logic             w_nxt_scl;
  logic             w_nxt_sda;
  logic             w_nxt_done;
  logic             w_nxt_ack_error;
  logic [6:0]       w_nxt_addr;
  logic [7:0]       w_nxt_d0;
  logic [7:0]       w_nxt_d1;

  logic             w_q_end;
  logic             w_phase_end;
  logic [7:0]       w_tx_byte;

  assign w_q_end     = (r_div == DIV_LAST);
  assign w_phase_end = w_q_end && (r_q == 2'd3);

  // Byte that will be on the wire in the next cycle; only consulted in BIT.
  always_comb begin
    w_tx_byte = r_d1;
    case (w_nxt_byte)
      2'd0:    w_tx_byte = {r_addr, 1'b0};
      2'd1:    w_tx_byte = r_d0;
      default: w_tx_byte = r_d1;
    endcase
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_q         = r_q;
    w_nxt_div       = r_div;
    w_nxt_bit       = r_bit;
    w_nxt_byte      = r_byte;
    w_nxt_done      = 1'b0;
    w_nxt_ack_error = r_ack_error;
    w_nxt_addr      = r_addr;
    w_nxt_d0        = r_d0;
    w_nxt_d1        = r_d1;

    // Quarter timebase runs only while a transaction is active.
    if (r_state != S_IDLE) begin
      if (w_q_end) begin
        w_nxt_div = '0;
        w_nxt_q   = r_q + 2'd1;
      end else begin
        w_nxt_div = r_div + 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_nxt_state     = S_START;
          w_nxt_q         = 2'd0;
          w_nxt_div       = '0;
          w_nxt_bit       = 3'd7;
          w_nxt_byte      = 2'd0;
          w_nxt_ack_error = 1'b0;
          w_nxt_addr      = bus.address;
          w_nxt_d0        = bus.data_0;
          w_nxt_d1        = bus.data_1;
        end
      end
      S_START: begin
        if (w_phase_end) w_nxt_state = S_BIT;
      end
      S_BIT: begin
        if (w_phase_end) begin
          if (r_bit == 3'd0) w_nxt_state = S_ACK;
          else               w_nxt_bit   = r_bit - 3'd1;
        end
      end
      S_ACK: begin
        // Slave answer is taken on the last clk of q2, mid SCL-high.
        if ((r_q == 2'd2) && w_q_end && bus.sda_i) w_nxt_ack_error = 1'b1;
        if (w_phase_end) begin
          // ack_error was cleared at accept, so it reflects this transaction only.
          if (r_ack_error || (r_byte == 2'd2)) begin
            w_nxt_state = S_STOP;
          end else begin
            w_nxt_state = S_BIT;
            w_nxt_byte  = r_byte + 2'd1;
            w_nxt_bit   = 3'd7;
          end
        end
      end
      S_STOP: begin
        if (w_phase_end) begin
          w_nxt_state = S_IDLE;
          w_nxt_done  = 1'b1;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Pad levels are derived from the next state so they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    w_nxt_scl = 1'b1;
    w_nxt_sda = 1'b1;
    case (w_nxt_state)
      S_START: begin
        w_nxt_scl = 1'b1;
        w_nxt_sda = ~w_nxt_q[1];
      end
      S_BIT: begin
        w_nxt_scl = w_nxt_q[1];
        w_nxt_sda = w_tx_byte[w_nxt_bit];
      end
      S_ACK: begin
        w_nxt_scl = w_nxt_q[1];
        w_nxt_sda = 1'b1;
      end
      S_STOP: begin
        w_nxt_scl = (w_nxt_q != 2'd0);
        w_nxt_sda = w_nxt_q[1];
      end
      default: begin
        w_nxt_scl = 1'b1;
        w_nxt_sda = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_q         <= 2'd0;
      r_div       <= '0;
      r_bit       <= 3'd0;
      r_byte      <= 2'd0;
      r_scl       <= 1'b1;
      r_sda       <= 1'b1;
      r_done      <= 1'b0;
      r_ack_error <= 1'b0;
      r_addr      <= 7'd0;
      r_d0        <= 8'd0;
      r_d1        <= 8'd0;
    end else begin
      r_state     <= w_nxt_state;
      r_q         <= w_nxt_q;
      r_div       <= w_nxt_div;
      r_bit       <= w_nxt_bit;
      r_byte      <= w_nxt_byte;
      r_scl       <= w_nxt_scl;
      r_sda       <= w_nxt_sda;
      r_done      <= w_nxt_done;
      r_ack_error <= w_nxt_ack_error;
      r_addr      <= w_nxt_addr;
      r_d0        <= w_nxt_d0;
      r_d1        <= w_nxt_d1;
    end
  end

  // Start is folded in so a sequencer sees busy in its own start cycle.
  assign bus.busy      = (r_state != S_IDLE) || bus.start;
  assign bus.done      = r_done;
  assign bus.ack_error = r_ack_error;
  assign bus.scl_o     = r_scl;
  assign bus.sda_o     = r_sda;

endmodule

// File: tb/tb_i2c_write_master.sv
// tb_i2c_write_master
//   Drives transactions from a vector table plus hand-written sequences
//   (ignored start, mid-transfer reset, back-to-back sequencer drive).
//   A bus monitor decodes START/STOP and bytes at SCL rise, acts as the
//   acknowledging slave, and pops expected bytes from a scoreboard queue.
module tb_i2c_write_master;
  localparam int CD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_write_master_if bus();

  i2c_write_master #(.CLK_DIV(CD)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  logic slave_pull = 1'b0;
  assign bus.sda_i = bus.sda_o & ~slave_pull;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] d0;
    logic [7:0] d1;
    int         nack_sel;   // 0 = slave ACKs all, k = NACK on byte k
    int         exp_busy;
    logic       exp_err;
  } vec_t;

  logic [7:0] exp_q[$];
  int nack_sel  = 0;
  int bit_cnt   = 0;
  int byte_idx  = 0;
  int start_cnt = 0;
  int stop_cnt  = 0;
  int done_cnt  = 0;
  logic [7:0] shreg = 8'h00;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus monitor and slave model.
  always @(negedge clk) begin
    logic scl_b, sda_b;
    scl_b = bus.scl_o;
    sda_b = bus.sda_i;
    if (rst) begin
      bit_cnt    = 0;
      slave_pull = 1'b0;
    end else begin
      if (bus.done) done_cnt++;
      if (scl_b && prev_scl && (sda_b != prev_sda)) begin
        if (!sda_b) begin
          start_cnt++;
          bit_cnt  = 0;
          byte_idx = 0;
        end else begin
          stop_cnt++;
          // The STOP's own SCL pulse registers as one stray bit after an ACK slot.
          chk("stop_after_ack_slot", bit_cnt, 1);
          bit_cnt = 0;
        end
      end else if (scl_b && !prev_scl) begin
        if (bit_cnt < 8) begin
          shreg = {shreg[6:0], sda_b};
          bit_cnt++;
          if (bit_cnt == 8) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_byte: got %0h expected none (t=%0t)", shreg, $time);
            end else begin
              chk("byte_on_bus", shreg, exp_q.pop_front());
            end
          end
        end else begin
          bit_cnt = 0;
          byte_idx++;
        end
      end else if (!scl_b && prev_scl) begin
        slave_pull = (bit_cnt == 8) && ((byte_idx + 1) != nack_sel);
      end
    end
    prev_scl = scl_b;
    prev_sda = sda_b;
  end

  task automatic push_expected(input logic [6:0] a, input logic [7:0] d0, input logic [7:0] d1,
                               input int ns);
    exp_q.push_back({a, 1'b0});
    if (ns == 0 || ns >= 2) exp_q.push_back(d0);
    if (ns == 0 || ns >= 3) exp_q.push_back(d1);
  endtask

  task automatic run_txn(input vec_t v, input int extra_at);
    int s0, p0, dc0, bcnt;
    nack_sel = v.nack_sel;
    s0  = start_cnt;
    p0  = stop_cnt;
    dc0 = done_cnt;
    @(negedge clk);
    bus.address = v.addr;
    bus.data_0  = v.d0;
    bus.data_1  = v.d1;
    bus.start   = 1'b1;
    push_expected(v.addr, v.d0, v.d1, v.nack_sel);
    #1 chk("busy_in_start_cycle", bus.busy, 1);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.address = 7'($urandom);
    bus.data_0  = 8'($urandom);
    bus.data_1  = 8'($urandom);
    bcnt = 0;
    while (bus.busy && bcnt < 2000) begin
      bcnt++;
      bus.start = (bcnt == extra_at);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("busy_cycles", bcnt, v.exp_busy);
    chk("done_at_end", bus.done, 1);
    chk("ack_error_at_done", bus.ack_error, v.exp_err);
    repeat (3) @(negedge clk);
    chk("done_pulse_count", done_cnt - dc0, 1);
    chk("start_cond_count", start_cnt - s0, 1);
    chk("stop_cond_count", stop_cnt - p0, 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("ack_error_sticky", bus.ack_error, v.exp_err);
    chk("idle_released", {bus.busy, bus.scl_o, bus.sda_o}, 3'b011);
  endtask

  vec_t vecs[6];

  initial begin
    int n, cyc, last, s0, p0, dc0;
    logic [6:0] sa;
    logic [7:0] sd0, sd1;

    vecs[0] = '{7'h39, 8'h41, 8'h10, 0, 464, 1'b0};
    vecs[1] = '{7'h39, 8'h41, 8'h10, 1, 176, 1'b1};
    vecs[2] = '{7'h39, 8'h41, 8'h10, 3, 464, 1'b1};
    vecs[3] = '{7'h55, 8'hA5, 8'hFF, 0, 464, 1'b0};
    vecs[4] = '{7'h7F, 8'h00, 8'h80, 2, 320, 1'b1};
    vecs[5] = '{7'h00, 8'hFF, 8'h01, 0, 464, 1'b0};

    bus.start   = 1'b0;
    bus.address = 7'h00;
    bus.data_0  = 8'h00;
    bus.data_1  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_scl", bus.scl_o, 1);
    chk("reset_sda", bus.sda_o, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_ack_error", bus.ack_error, 0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], 0);

    // Second start mid-transfer must be ignored.
    run_txn(vecs[0], 100);

    // Reset 200 clks into a transfer, then a clean transfer.
    nack_sel = 0;
    @(negedge clk);
    bus.address = 7'h39;
    bus.data_0  = 8'h41;
    bus.data_1  = 8'h10;
    bus.start   = 1'b1;
    push_expected(7'h39, 8'h41, 8'h10, 0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (199) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_scl", bus.scl_o, 1);
    chk("midrst_sda", bus.sda_o, 1);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ack_error", bus.ack_error, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    run_txn(vecs[0], 0);

    // Sequencer style: start held high, next transaction accepted in the done cycle.
    nack_sel = 0;
    s0  = start_cnt;
    p0  = stop_cnt;
    dc0 = done_cnt;
    @(negedge clk);
    sa = 7'h10; sd0 = 8'h20; sd1 = 8'h30;
    bus.address = sa; bus.data_0 = sd0; bus.data_1 = sd1;
    push_expected(sa, sd0, sd1, 0);
    bus.start = 1'b1;
    #1 chk("seq_busy_in_start_cycle", bus.busy, 1);
    n = 0; cyc = 0; last = -1;
    while (n < 25 && cyc < 25 * 500) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        n++;
        if (last >= 0) chk("seq_done_spacing", cyc - last, 465);
        last = cyc;
        if (n < 25) begin
          chk("seq_busy_in_done_cycle", bus.busy, 1);
          sa  = 7'($urandom);
          sd0 = 8'($urandom);
          sd1 = 8'($urandom);
          bus.address = sa; bus.data_0 = sd0; bus.data_1 = sd1;
          push_expected(sa, sd0, sd1, 0);
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    chk("seq_transactions", n, 25);
    repeat (5) @(negedge clk);
    chk("seq_done_pulses", done_cnt - dc0, 25);
    chk("seq_start_conds", start_cnt - s0, 25);
    chk("seq_stop_conds", stop_cnt - p0, 25);
    chk("seq_scoreboard_drained", exp_q.size(), 0);
    chk("seq_idle", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
